// File: rtl/jtdd_char_rom_slot.sv
// rtl/jtdd_char_rom_slot.sv - one-word cache between the character layer and SDRAM
// A miss issues one SDRAM word read; hits are served combinationally from the cached word.
module jtdd_char_rom_slot #(
   parameter int          AW     = 16,
   parameter logic [21:0] OFFSET = 22'd0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [AW-1:0] rom_addr,
   output logic [7:0]    rom_data,
   output logic          rom_ok,
   input  logic          downloading,
   output logic          sdram_req,
   output logic [21:0]   sdram_addr,
   input  logic          sdram_ack,
   input  logic          data_rdy,
   input  logic [15:0]   sdram_data
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_ACK  = 2'd1,
      WAIT_DATA = 2'd2
   } state_t;

   state_t        state, state_next;
   logic [15:0]   word;
   logic [AW-2:0] tag;
   logic [AW-2:0] req_addr;
   logic          valid;
   logic          hit;
   logic          load_req;
   logic          clr_req;
   logic          fill;

   assign hit        = valid & (tag == rom_addr[AW-1:1]);
   assign rom_ok     = hit & ~downloading;
   assign rom_data   = rom_addr[0] ? word[15:8] : word[7:0];
   assign sdram_addr = OFFSET + 22'(req_addr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Address changes in flight are not tracked; IDLE re-evaluates the miss after the fill.
   always_comb begin
      state_next = state;
      load_req   = 1'b0;
      clr_req    = 1'b0;
      fill       = 1'b0;
      case (state)
         IDLE: begin
            if (!hit && !downloading) begin
               load_req   = 1'b1;
               state_next = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (sdram_ack) begin
               clr_req = 1'b1;
               if (data_rdy) begin
                  fill       = 1'b1;
                  state_next = IDLE;
               end else begin
                  state_next = WAIT_DATA;
               end
            end
         end
         WAIT_DATA: begin
            if (data_rdy) begin
               fill       = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sdram_req <= 1'b0;
         req_addr  <= '0;
         word      <= '0;
         tag       <= '0;
         valid     <= 1'b0;
      end else begin
         if (load_req) begin
            req_addr  <= rom_addr[AW-1:1];
            sdram_req <= 1'b1;
         end else if (clr_req) begin
            sdram_req <= 1'b0;
         end
         // A download invalidates the slot and discards any read that lands during it.
         if (downloading) begin
            valid <= 1'b0;
         end else if (fill) begin
            word  <= sdram_data;
            tag   <= req_addr;
            valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_jtdd_char_rom_slot.sv
// tb/tb_jtdd_char_rom_slot.sv - directed bench for jtdd_char_rom_slot
// Two instances share stimulus; the second exercises OFFSET wrap-around.
module tb_jtdd_char_rom_slot;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] rom_addr;
   logic        downloading;
   logic        sdram_ack;
   logic        data_rdy;
   logic [15:0] sdram_data;
   logic [7:0]  rom_data, rom_data2;
   logic        rom_ok, rom_ok2;
   logic        sdram_req, sdram_req2;
   logic [21:0] sdram_addr, sdram_addr2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   jtdd_char_rom_slot #(.AW(16), .OFFSET(22'h10000)) dut (
      .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_data(rom_data),
      .rom_ok(rom_ok), .downloading(downloading), .sdram_req(sdram_req),
      .sdram_addr(sdram_addr), .sdram_ack(sdram_ack), .data_rdy(data_rdy),
      .sdram_data(sdram_data)
   );

   jtdd_char_rom_slot #(.AW(16), .OFFSET(22'h3FFFFF)) dut2 (
      .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_data(rom_data2),
      .rom_ok(rom_ok2), .downloading(downloading), .sdram_req(sdram_req2),
      .sdram_addr(sdram_addr2), .sdram_ack(sdram_ack), .data_rdy(data_rdy),
      .sdram_data(sdram_data)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; rom_addr = 16'h1235; downloading = 1'b0;
      sdram_ack = 1'b0; data_rdy = 1'b0; sdram_data = 16'h0000;
      step(); step();
      total++; if (rom_ok !== 1'b0) begin bad++; $display("FAIL reset_rom_ok got=%b want=0", rom_ok); end
      total++; if (rom_data !== 8'h00) begin bad++; $display("FAIL reset_rom_data got=%h want=00", rom_data); end
      total++; if (sdram_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", sdram_req); end
      total++; if (sdram_addr !== 22'h10000) begin bad++; $display("FAIL reset_addr got=%h want=10000", sdram_addr); end
      total++; if (sdram_addr2 !== 22'h3FFFFF) begin bad++; $display("FAIL reset_addr2 got=%h want=3fffff", sdram_addr2); end
   endtask

   task automatic test_cold_miss();
      rst_n = 1'b1;
      step();
      total++; if (sdram_req !== 1'b1) begin bad++; $display("FAIL cold_req got=%b want=1", sdram_req); end
      total++; if (sdram_addr !== 22'h1091A) begin bad++; $display("FAIL cold_addr got=%h want=1091a", sdram_addr); end
      total++; if (rom_ok !== 1'b0) begin bad++; $display("FAIL cold_rom_ok got=%b want=0", rom_ok); end
      step(); step();
      total++; if (sdram_req !== 1'b1) begin bad++; $display("FAIL cold_req_hold got=%b want=1", sdram_req); end
      sdram_ack = 1'b1;
      step();
      sdram_ack = 1'b0;
      total++; if (sdram_req !== 1'b0) begin bad++; $display("FAIL cold_req_drop got=%b want=0", sdram_req); end
      step();
      total++; if (rom_ok !== 1'b0) begin bad++; $display("FAIL cold_wait_ok got=%b want=0", rom_ok); end
      data_rdy = 1'b1; sdram_data = 16'hBEEF;
      step();
      data_rdy = 1'b0; sdram_data = 16'h0000;
      total++; if (rom_ok !== 1'b1) begin bad++; $display("FAIL cold_fill_ok got=%b want=1", rom_ok); end
      total++; if (rom_data !== 8'hBE) begin bad++; $display("FAIL cold_fill_data got=%h want=be", rom_data); end
      step();
      total++; if (sdram_req !== 1'b0) begin bad++; $display("FAIL cold_no_rereq got=%b want=0", sdram_req); end
   endtask

   task automatic test_hit();
      rom_addr = 16'h1234;
      #1;
      total++; if (rom_ok !== 1'b1) begin bad++; $display("FAIL hit_ok got=%b want=1", rom_ok); end
      total++; if (rom_data !== 8'hEF) begin bad++; $display("FAIL hit_data got=%h want=ef", rom_data); end
      step();
      total++; if (sdram_req !== 1'b0) begin bad++; $display("FAIL hit_no_req got=%b want=0", sdram_req); end
   endtask

   task automatic test_addr_change();
      rom_addr = 16'h0002;
      #1;
      total++; if (rom_ok !== 1'b0) begin bad++; $display("FAIL chg_miss_ok got=%b want=0", rom_ok); end
      step();
      total++; if (sdram_req !== 1'b1) begin bad++; $display("FAIL chg_req got=%b want=1", sdram_req); end
      total++; if (sdram_addr !== 22'h10001) begin bad++; $display("FAIL chg_addr got=%h want=10001", sdram_addr); end
      total++; if (sdram_addr2 !== 22'h000000) begin bad++; $display("FAIL wrap_addr got=%h want=000000", sdram_addr2); end
      rom_addr = 16'h0100; sdram_ack = 1'b1;
      step();
      sdram_ack = 1'b0;
      total++; if (sdram_req !== 1'b0) begin bad++; $display("FAIL chg_req_drop got=%b want=0", sdram_req); end
      total++; if (sdram_addr !== 22'h10001) begin bad++; $display("FAIL chg_addr_kept got=%h want=10001", sdram_addr); end
      data_rdy = 1'b1; sdram_data = 16'h1234;
      step();
      data_rdy = 1'b0;
      total++; if (rom_ok !== 1'b0) begin bad++; $display("FAIL chg_fill_ok got=%b want=0", rom_ok); end
      total++; if (sdram_req !== 1'b0) begin bad++; $display("FAIL chg_idle_req got=%b want=0", sdram_req); end
      step();
      total++; if (sdram_req !== 1'b1) begin bad++; $display("FAIL chg_rereq got=%b want=1", sdram_req); end
      total++; if (sdram_addr !== 22'h10080) begin bad++; $display("FAIL chg_rereq_addr got=%h want=10080", sdram_addr); end
      rom_addr = 16'h0003;
      #1;
      total++; if (rom_ok !== 1'b1) begin bad++; $display("FAIL chg_old_tag_ok got=%b want=1", rom_ok); end
      total++; if (rom_data !== 8'h12) begin bad++; $display("FAIL chg_old_tag_data got=%h want=12", rom_data); end
   endtask

   task automatic test_back_to_back();
      sdram_ack = 1'b1; data_rdy = 1'b1; sdram_data = 16'hA55A;
      step();
      sdram_ack = 1'b0; data_rdy = 1'b0;
      rom_addr = 16'h0100;
      #1;
      total++; if (sdram_req !== 1'b0) begin bad++; $display("FAIL b2b_req got=%b want=0", sdram_req); end
      total++; if (rom_ok !== 1'b1) begin bad++; $display("FAIL b2b_ok got=%b want=1", rom_ok); end
      total++; if (rom_data !== 8'h5A) begin bad++; $display("FAIL b2b_data got=%h want=5a", rom_data); end
      step();
      total++; if (sdram_req !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b want=0", sdram_req); end
   endtask

   task automatic test_download();
      downloading = 1'b1;
      #1;
      total++; if (rom_ok !== 1'b0) begin bad++; $display("FAIL dl_ok_now got=%b want=0", rom_ok); end
      for (int i = 0; i < 10; i++) begin
         step();
         total++; if (sdram_req !== 1'b0 || rom_ok !== 1'b0) begin
            bad++; $display("FAIL dl_cycle%0d req=%b ok=%b want 0,0", i, sdram_req, rom_ok);
         end
      end
      downloading = 1'b0;
      #1;
      total++; if (rom_ok !== 1'b0) begin bad++; $display("FAIL dl_invalid got=%b want=0", rom_ok); end
      step();
      total++; if (sdram_req !== 1'b1) begin bad++; $display("FAIL dl_rereq got=%b want=1", sdram_req); end
      total++; if (sdram_addr !== 22'h10080) begin bad++; $display("FAIL dl_rereq_addr got=%h want=10080", sdram_addr); end
      sdram_ack = 1'b1;
      step();
      sdram_ack = 1'b0; data_rdy = 1'b1; sdram_data = 16'h0F0E;
      step();
      data_rdy = 1'b0;
      total++; if (rom_ok !== 1'b1 || rom_data !== 8'h0E) begin
         bad++; $display("FAIL dl_refill ok=%b data=%h want 1,0e", rom_ok, rom_data);
      end
   endtask

   task automatic test_download_discard();
      rom_addr = 16'h0200;
      step();
      total++; if (sdram_req !== 1'b1) begin bad++; $display("FAIL disc_req got=%b want=1", sdram_req); end
      downloading = 1'b1; sdram_ack = 1'b1;
      step();
      sdram_ack = 1'b0; data_rdy = 1'b1; sdram_data = 16'hCAFE;
      step();
      data_rdy = 1'b0; downloading = 1'b0;
      #1;
      total++; if (rom_ok !== 1'b0) begin bad++; $display("FAIL disc_ok got=%b want=0", rom_ok); end
      step();
      total++; if (sdram_req !== 1'b1) begin bad++; $display("FAIL disc_rereq got=%b want=1", sdram_req); end
      total++; if (sdram_addr !== 22'h10100) begin bad++; $display("FAIL disc_addr got=%h want=10100", sdram_addr); end
   endtask

   task automatic test_reset_mid();
      rst_n = 1'b0;
      #1;
      total++; if (sdram_req !== 1'b0) begin bad++; $display("FAIL rmid_req got=%b want=0", sdram_req); end
      total++; if (sdram_addr !== 22'h10000) begin bad++; $display("FAIL rmid_addr got=%h want=10000", sdram_addr); end
      step();
      rst_n = 1'b1;
      #1;
      total++; if (sdram_req !== 1'b0) begin bad++; $display("FAIL rmid_release got=%b want=0", sdram_req); end
      step();
      total++; if (sdram_req !== 1'b1) begin bad++; $display("FAIL rmid_rereq got=%b want=1", sdram_req); end
      total++; if (sdram_addr !== 22'h10100) begin bad++; $display("FAIL rmid_rereq_addr got=%h want=10100", sdram_addr); end
   endtask

   initial begin
      test_reset();
      test_cold_miss();
      test_hit();
      test_addr_change();
      test_back_to_back();
      test_download();
      test_download_discard();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
